// File: rtl/axi_cmd_scheduler.sv
// Dual-queue AXI command scheduler: independent read and write sequencers fed from FIFO
// queues, with a read-after-write address hazard check and a shared completion strobe.
module axi_cmd_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_rw,
  input  logic [7:0]   cmd_addr,
  input  logic [3:0]   cmd_len,
  input  logic [3:0]   cmd_id,
  input  logic [127:0] cmd_wdata,
  output logic         rd_en,
  output logic [15:0]  tb_R,
  output logic         wr_en,
  output logic [15:0]  tb_W,
  output logic [127:0] INDATA,
  input  logic         RVALID,
  input  logic         RREADY,
  input  logic         RLAST,
  input  logic         BVALID,
  input  logic         BREADY,
  input  logic [4:0]   BRESP,
  output logic         done_valid,
  output logic         done_rw,
  output logic [3:0]   done_id,
  output logic         done_err,
  output logic         busy
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [7:0]  ToLimit = 8'(TIMEOUT);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DONE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_DONE} w_state_t;

  r_state_t r_rstate, w_rstate_nxt;
  w_state_t r_wstate, w_wstate_nxt;

  // Queue storage: entry = {addr, len, id}; write data kept alongside.
  logic [15:0]   r_rq_mem [DEPTH];
  logic [15:0]   r_wq_mem [DEPTH];
  logic [127:0]  r_wq_dat [DEPTH];
  logic [AW-1:0] r_rq_wptr, r_rq_rptr, r_wq_wptr, r_wq_rptr;
  logic [AW:0]   r_rq_cnt, r_wq_cnt;

  logic w_rq_full, w_rq_empty, w_wq_full, w_wq_empty;
  logic w_rq_push, w_rq_pop, w_wq_push, w_wq_pop;
  logic [15:0] w_rq_head;
  logic w_hazard;

  logic [15:0]  r_tb_r, r_tb_w;
  logic [127:0] r_indata;
  logic [7:0]   r_rcnt, r_wcnt;
  logic [7:0]   w_rcnt_sat, w_wcnt_sat;
  logic         w_rto, w_wto;
  logic         r_rerr, r_werr;
  logic         w_rhs, w_whs;

  assign w_rq_full  = (r_rq_cnt == FullCnt);
  assign w_wq_full  = (r_wq_cnt == FullCnt);
  assign w_rq_empty = (r_rq_cnt == '0);
  assign w_wq_empty = (r_wq_cnt == '0);
  assign w_rq_head  = r_rq_mem[r_rq_rptr];

  assign cmd_ready = rst & (cmd_rw ? ~w_wq_full : ~w_rq_full);
  assign w_rq_push = cmd_valid & cmd_ready & ~cmd_rw;
  assign w_wq_push = cmd_valid & cmd_ready & cmd_rw;

  assign w_hazard = ((r_wstate == W_ISSUE) || (r_wstate == W_WAIT)) &&
                    (r_tb_w[15:8] == w_rq_head[15:8]);

  assign w_rcnt_sat = (r_rcnt == 8'hFF) ? 8'hFF : r_rcnt + 8'd1;
  assign w_wcnt_sat = (r_wcnt == 8'hFF) ? 8'hFF : r_wcnt + 8'd1;
  assign w_rto = (w_rcnt_sat >= ToLimit);
  assign w_wto = (w_wcnt_sat >= ToLimit);
  assign w_rhs = RVALID & RREADY & RLAST;
  assign w_whs = BVALID & BREADY;

  assign tb_R   = r_tb_r;
  assign tb_W   = r_tb_w;
  assign INDATA = r_indata;
  assign busy   = ~w_rq_empty | ~w_wq_empty | (r_rstate != R_IDLE) | (r_wstate != W_IDLE);

  always_ff @(posedge clk) begin
    if (w_rq_push) r_rq_mem[r_rq_wptr] <= {cmd_addr, cmd_len, cmd_id};
    if (w_wq_push) begin
      r_wq_mem[r_wq_wptr] <= {cmd_addr, cmd_len, cmd_id};
      r_wq_dat[r_wq_wptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rq_wptr <= '0;
      r_rq_rptr <= '0;
      r_rq_cnt  <= '0;
      r_wq_wptr <= '0;
      r_wq_rptr <= '0;
      r_wq_cnt  <= '0;
    end else begin
      if (w_rq_push) r_rq_wptr <= r_rq_wptr + AW'(1);
      if (w_rq_pop)  r_rq_rptr <= r_rq_rptr + AW'(1);
      if (w_wq_push) r_wq_wptr <= r_wq_wptr + AW'(1);
      if (w_wq_pop)  r_wq_rptr <= r_wq_rptr + AW'(1);
      r_rq_cnt <= r_rq_cnt + (AW+1)'(w_rq_push) - (AW+1)'(w_rq_pop);
      r_wq_cnt <= r_wq_cnt + (AW+1)'(w_wq_push) - (AW+1)'(w_wq_pop);
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rq_pop     = 1'b0;
    rd_en        = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (!w_rq_empty && !w_hazard) begin
          w_rq_pop     = 1'b1;
          w_rstate_nxt = R_ISSUE;
        end
      end
      R_ISSUE: begin
        rd_en        = 1'b1;
        w_rstate_nxt = R_WAIT;
      end
      R_WAIT:  if (w_rhs || w_rto) w_rstate_nxt = R_DONE;
      R_DONE:  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wq_pop     = 1'b0;
    wr_en        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (!w_wq_empty) begin
          w_wq_pop     = 1'b1;
          w_wstate_nxt = W_ISSUE;
        end
      end
      W_ISSUE: begin
        wr_en        = 1'b1;
        w_wstate_nxt = W_WAIT;
      end
      W_WAIT:  if (w_whs || w_wto) w_wstate_nxt = W_DONE;
      // A coinciding read completion takes the strobe; hold until it is gone.
      W_DONE:  if (r_rstate != R_DONE) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_tb_r   <= '0;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_rq_pop) r_tb_r <= w_rq_head;
      if (r_rstate == R_ISSUE) r_rcnt <= '0;
      else if (r_rstate == R_WAIT) begin
        r_rcnt <= w_rcnt_sat;
        if (w_rhs)      r_rerr <= 1'b0;
        else if (w_rto) r_rerr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_tb_w   <= '0;
      r_indata <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_wq_pop) begin
        r_tb_w   <= r_wq_mem[r_wq_rptr];
        r_indata <= r_wq_dat[r_wq_rptr];
      end
      if (r_wstate == W_ISSUE) r_wcnt <= '0;
      else if (r_wstate == W_WAIT) begin
        r_wcnt <= w_wcnt_sat;
        if (w_whs)      r_werr <= (BRESP != 5'd0);
        else if (w_wto) r_werr <= 1'b1;
      end
    end
  end

  always_comb begin
    done_valid = 1'b0;
    done_rw    = 1'b0;
    done_id    = 4'd0;
    done_err   = 1'b0;
    if (r_rstate == R_DONE) begin
      done_valid = 1'b1;
      done_id    = r_tb_r[3:0];
      done_err   = r_rerr;
    end else if (r_wstate == W_DONE) begin
      done_valid = 1'b1;
      done_rw    = 1'b1;
      done_id    = r_tb_w[3:0];
      done_err   = r_werr;
    end
  end

endmodule

// File: tb/tb_axi_cmd_scheduler.sv
// Directed bench for axi_cmd_scheduler; outputs sampled on the falling clock edge.
module tb_axi_cmd_scheduler;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 32;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready, cmd_rw;
  logic [7:0]   cmd_addr;
  logic [3:0]   cmd_len, cmd_id;
  logic [127:0] cmd_wdata;
  logic         rd_en, wr_en;
  logic [15:0]  tb_R, tb_W;
  logic [127:0] INDATA;
  logic         RVALID, RREADY, RLAST, BVALID, BREADY;
  logic [4:0]   BRESP;
  logic         done_valid, done_rw, done_err, busy;
  logic [3:0]   done_id;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  axi_cmd_scheduler #(.DEPTH(Depth), .TIMEOUT(Timeout)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_wdata(cmd_wdata),
    .rd_en(rd_en), .tb_R(tb_R), .wr_en(wr_en), .tb_W(tb_W), .INDATA(INDATA),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .done_valid(done_valid), .done_rw(done_rw), .done_id(done_id),
    .done_err(done_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_valid) n_done = n_done + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one command at the current falling edge; returns one cycle later.
  task automatic push(input logic rw, input logic [7:0] a, input logic [3:0] l,
                      input logic [3:0] id, input logic [127:0] wd);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_id    = id;
    cmd_wdata = wd;
    #1 check("push_rdy", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    while (!rd_en && n < 64) begin @(negedge clk); n++; end
    check("rd_en_seen", rd_en, 1'b1);
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    while (!wr_en && n < 64) begin @(negedge clk); n++; end
    check("wr_en_seen", wr_en, 1'b1);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done_valid && n < max) begin @(negedge clk); n++; end
    check("done_seen", done_valid, 1'b1);
  endtask

  task automatic r_hs();
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    @(negedge clk);
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
  endtask

  task automatic b_hs(input logic [4:0] code);
    BVALID = 1'b1; BREADY = 1'b1; BRESP = code;
    @(negedge clk);
    BVALID = 1'b0; BREADY = 1'b0; BRESP = 5'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0, cnt_r, cnt_w;
    logic [127:0] wd;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    cmd_wdata = '0;
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    BVALID = 1'b0; BREADY = 1'b0; BRESP = '0;
    #2 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_tb_r", tb_R, 16'h0);
    check("rst_done_valid", done_valid, 1'b0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_rst_ready", cmd_ready, 1'b1);
    @(negedge clk);

    // Basic read
    push(1'b0, 8'h40, 4'd3, 4'd2, '0);
    wait_rd(n);
    check("rd_latency", n, 1);
    check("rd_tb_r", tb_R, 16'h4032);
    @(negedge clk);
    check("rd_pulse_1cyc", rd_en, 1'b0);
    check("rd_tb_r_stable", tb_R, 16'h4032);
    r_hs();
    wait_done(8, n);
    check("rd_done_rw", done_rw, 1'b0);
    check("rd_done_id", done_id, 4'd2);
    check("rd_done_err", done_err, 1'b0);
    @(negedge clk);
    check("rd_done_1cyc", done_valid, 1'b0);

    // Write with OKAY then SLVERR response
    wd = {4{32'hA5C3_1E0F}};
    push(1'b1, 8'h10, 4'd0, 4'd5, wd);
    wait_wr(n);
    check("wr_latency", n, 1);
    check("wr_tb_w", tb_W, 16'h1005);
    check("wr_indata", INDATA, wd);
    @(negedge clk);
    b_hs(5'd0);
    wait_done(8, n);
    check("wr_done_rw", done_rw, 1'b1);
    check("wr_done_id", done_id, 4'd5);
    check("wr_done_err0", done_err, 1'b0);
    push(1'b1, 8'h10, 4'd0, 4'd5, wd);
    wait_wr(n);
    check("wr2_tb_w", tb_W, 16'h1005);
    @(negedge clk);
    b_hs(5'h02);
    wait_done(8, n);
    check("wr2_done_err1", done_err, 1'b1);
    @(negedge clk);

    // Read-after-write hazard on 0x20
    push(1'b1, 8'h20, 4'd0, 4'd7, '0);
    wait_wr(n);
    push(1'b0, 8'h20, 4'd0, 4'd8, '0);
    cnt_r = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_en) cnt_r++;
      @(negedge clk);
    end
    check("haz_rd_held", cnt_r, 0);
    check("haz_busy", busy, 1'b1);
    b_hs(5'd0);
    check("haz_wr_done", done_valid, 1'b1);
    check("haz_wr_done_rw", done_rw, 1'b1);
    wait_rd(n);
    check("haz_release_lat", n, 1);
    check("haz_tb_r", tb_R, 16'h2008);
    @(negedge clk);
    r_hs();
    wait_done(8, n);
    check("haz_rd_done_id", done_id, 4'd8);
    @(negedge clk);

    // Read timeout: no RLAST
    push(1'b0, 8'h50, 4'd1, 4'd3, '0);
    wait_rd(n);
    @(negedge clk);
    wait_done(Timeout + 10, n);
    check("to_cycles", n, Timeout);
    check("to_done_rw", done_rw, 1'b0);
    check("to_done_id", done_id, 4'd3);
    check("to_done_err", done_err, 1'b1);
    @(negedge clk);

    // Read and write completing in the same cycle
    push(1'b0, 8'h60, 4'd0, 4'd9, '0);
    push(1'b1, 8'h70, 4'd0, 4'd10, '0);
    wait_wr(n);
    @(negedge clk);
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    BVALID = 1'b1; BREADY = 1'b1; BRESP = 5'd0;
    @(negedge clk);
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    BVALID = 1'b0; BREADY = 1'b0;
    check("co_first_valid", done_valid, 1'b1);
    check("co_first_rw", done_rw, 1'b0);
    check("co_first_id", done_id, 4'd9);
    @(negedge clk);
    check("co_second_valid", done_valid, 1'b1);
    check("co_second_rw", done_rw, 1'b1);
    check("co_second_id", done_id, 4'd10);
    @(negedge clk);
    check("co_after", done_valid, 1'b0);

    // Full write queue: one write in flight, then five more offered
    push(1'b1, 8'h30, 4'd0, 4'd1, '0);
    wait_wr(n);
    for (int i = 0; i < 4; i++) push(1'b1, 8'h31 + 8'(i), 4'd0, 4'(i + 2), '0);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h35; cmd_id = 4'd6; cmd_len = 4'd0;
    #1 check("full_wr_ready", cmd_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("full_wr_ready_hold", cmd_ready, 1'b0);
    cmd_rw = 1'b0; cmd_addr = 8'h99; cmd_id = 4'd4;
    #1 check("full_rd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rd(n);
    check("full_rd_tb_r", tb_R, 16'h9904);
    @(negedge clk);

    // Reset during R_WAIT
    check("prerst_busy", busy, 1'b1);
    d0 = n_done;
    #2 rst = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b0;
    #1;
    check("mrst_cmd_ready", cmd_ready, 1'b0);
    check("mrst_rd_en", rd_en, 1'b0);
    check("mrst_wr_en", wr_en, 1'b0);
    check("mrst_tb_r", tb_R, 16'h0);
    check("mrst_tb_w", tb_W, 16'h0);
    check("mrst_indata", INDATA, 128'h0);
    check("mrst_done", {done_valid, done_rw, done_id, done_err}, 7'h0);
    check("mrst_busy", busy, 1'b0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cmd_rw = 1'b1;
    #1 check("mrst_release_ready", cmd_ready, 1'b1);
    cnt_r = 0;
    cnt_w = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_en) cnt_r++;
      if (wr_en) cnt_w++;
    end
    check("mrst_no_rd", cnt_r, 0);
    check("mrst_no_wr", cnt_w, 0);
    check("mrst_no_done", n_done - d0, 0);
    check("mrst_idle_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
